multicycle_control_fsm: RTL and testbench

- Main control state machine for the sequential (multi-cycle) RV32 core.
- Sits directly upstream of the ALU control block: drives the 2-bit aluop (00 add for address calc, 01 subtract for branch compare, 10 use func3/func7) plus datapath enables and memory handshakes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Supports R-type, lw, sw and beq; all other opcodes are flagged illegal.

---
 rtl/multicycle_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32 core: sequences fetch/decode/execute/memory/writeback
// for R-type, lw, sw and beq, with a ready watchdog that turns a stalled bus into a bus error.
module multicycle_control_fsm #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_branch,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_b,
  output logic [1:0] aluop,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic       instr_retired,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_R = 3'd2,
    WB_R   = 3'd3,
    ADDR   = 3'd4,
    MEM_RD = 3'd5,
    WB_MEM = 3'd6,
    MEM_WR = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam logic [TW-1:0] WD_LAST = WD_EN ? TW'(TIMEOUT - 1) : '0;

  state_t        state_reg, state_next;
  logic [TW-1:0] wd_reg, wd_next;
  logic          waiting;
  logic          ready_sel;
  logic          expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
    end
  end

  // Ready arriving on the expiry cycle wins, so expiry is only declared while ready is low.
  always_comb begin
    waiting   = (state_reg == FETCH) || (state_reg == MEM_RD) || (state_reg == MEM_WR);
    ready_sel = (state_reg == FETCH) ? imem_ready : dmem_ready;
    expire    = WD_EN && waiting && !ready_sel && (wd_reg == WD_LAST);
  end

  always_comb begin
    state_next    = state_reg;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_branch     = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_b     = 1'b0;
    aluop         = 2'b00;
    illegal_instr = 1'b0;
    bus_error     = expire;
    instr_retired = 1'b0;

    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end else if (expire) begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        state_next = FETCH;
        case (opcode)
          OP_R:         state_next = EXEC_R;
          OP_LW, OP_SW: state_next = ADDR;
          OP_BEQ: begin
            aluop         = 2'b01;
            pc_branch     = zero;
            instr_retired = 1'b1;
          end
          default:      illegal_instr = 1'b1;
        endcase
      end
      EXEC_R: begin
        aluop      = 2'b10;
        state_next = WB_R;
      end
      WB_R: begin
        aluop         = 2'b10;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      ADDR: begin
        alu_src_b  = 1'b1;
        state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        alu_src_b = 1'b1;
        dmem_req  = 1'b1;
        if (dmem_ready)  state_next = WB_MEM;
        else if (expire) state_next = FETCH;
      end
      WB_MEM: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      MEM_WR: begin
        alu_src_b = 1'b1;
        dmem_req  = 1'b1;
        dmem_we   = 1'b1;
        if (dmem_ready) begin
          instr_retired = 1'b1;
          state_next    = FETCH;
        end else if (expire) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

    // Counter only runs while stalled in one wait state; any transition or expiry restarts it.
    wd_next = (waiting && !ready_sel && !expire) ? wd_reg + TW'(1) : '0;

    if (reset) begin
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_branch     = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_b     = 1'b0;
      aluop         = 2'b00;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;
      instr_retired = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle scripts built from the instruction-level
// rules are replayed against the DUT with randomized don't-care inputs and ready delays.
module tb_multicycle_control_fsm;

  localparam int TIMEOUT = 16;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Expected-output bit masks: {imem_req,ir_write,pc_write,pc_branch,dmem_req,dmem_we,
  // reg_write,mem_to_reg,alu_src_b,aluop[1:0],illegal_instr,bus_error,instr_retired}
  localparam logic [13:0] O_IMREQ = 14'h2000;
  localparam logic [13:0] O_IRW   = 14'h1000;
  localparam logic [13:0] O_PCW   = 14'h0800;
  localparam logic [13:0] O_PCB   = 14'h0400;
  localparam logic [13:0] O_DREQ  = 14'h0200;
  localparam logic [13:0] O_DWE   = 14'h0100;
  localparam logic [13:0] O_RW    = 14'h0080;
  localparam logic [13:0] O_M2R   = 14'h0040;
  localparam logic [13:0] O_ASB   = 14'h0020;
  localparam logic [13:0] O_ALU_F = 14'h0010;
  localparam logic [13:0] O_ALU_S = 14'h0008;
  localparam logic [13:0] O_ILL   = 14'h0004;
  localparam logic [13:0] O_BERR  = 14'h0002;
  localparam logic [13:0] O_RET   = 14'h0001;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [13:0] out;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, pc_write, pc_branch, dmem_req, dmem_we;
  logic       reg_write, mem_to_reg, alu_src_b, illegal_instr, bus_error, instr_retired;
  logic [1:0] aluop;
  logic [2:0] state;

  int    vectors = 0;
  int    miscompares = 0;
  step_t q[$];

  multicycle_control_fsm #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .aluop(aluop), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .instr_retired(instr_retired), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  function automatic step_t rnd_step();
    step_t s;
    s.rst  = 1'b0;
    s.op   = 7'($urandom);
    s.zero = 1'($urandom);
    s.ir   = 1'($urandom);
    s.dr   = 1'($urandom);
    s.st   = '0;
    s.out  = '0;
    return s;
  endfunction

  // Instruction-level reference: appends the expected cycle-by-cycle script of one instruction.
  task automatic gen(input logic [6:0] op, input int fd, input int md, input logic zv);
    step_t       s;
    logic [13:0] base;
    bit          is_lw = (op == OP_LW);
    bit          is_sw = (op == OP_SW);
    for (int i = 0; i < 1000; i++) begin
      s = rnd_step(); s.st = 3'd0; s.ir = (i == fd);
      if (!s.ir && TIMEOUT > 0 && i == TIMEOUT - 1) begin
        s.out = O_IMREQ | O_BERR; q.push_back(s); return;
      end
      s.out = s.ir ? (O_IMREQ | O_IRW | O_PCW) : O_IMREQ;
      q.push_back(s);
      if (s.ir) break;
    end
    s = rnd_step(); s.op = op; s.st = 3'd1; s.zero = zv;
    if (op == OP_R) begin
      s.out = '0; q.push_back(s);
      s = rnd_step(); s.op = op; s.st = 3'd2; s.out = O_ALU_F; q.push_back(s);
      s = rnd_step(); s.op = op; s.st = 3'd3; s.out = O_ALU_F | O_RW | O_RET; q.push_back(s);
    end else if (is_lw || is_sw) begin
      s.out = '0; q.push_back(s);
      s = rnd_step(); s.op = op; s.st = 3'd4; s.out = O_ASB; q.push_back(s);
      base = O_ASB | O_DREQ | (is_sw ? O_DWE : 14'h0);
      for (int i = 0; i < 1000; i++) begin
        s = rnd_step(); s.op = op; s.st = is_lw ? 3'd5 : 3'd7; s.dr = (i == md);
        if (!s.dr && TIMEOUT > 0 && i == TIMEOUT - 1) begin
          s.out = base | O_BERR; q.push_back(s); return;
        end
        s.out = base | ((is_sw && s.dr) ? O_RET : 14'h0);
        q.push_back(s);
        if (s.dr) break;
      end
      if (is_lw) begin
        s = rnd_step(); s.op = op; s.st = 3'd6; s.out = O_RW | O_M2R | O_RET; q.push_back(s);
      end
    end else if (op == OP_BEQ) begin
      s.out = O_ALU_S | O_RET | (zv ? O_PCB : 14'h0); q.push_back(s);
    end else begin
      s.out = O_ILL; q.push_back(s);
    end
  endtask

  task automatic apply(input step_t s, output logic [2:0] st_o, output logic [13:0] out_o);
    @(negedge clk);
    reset = s.rst; opcode = s.op; zero = s.zero; imem_ready = s.ir; dmem_ready = s.dr;
    #1;
    st_o  = state;
    out_o = {imem_req, ir_write, pc_write, pc_branch, dmem_req, dmem_we, reg_write,
             mem_to_reg, alu_src_b, aluop, illegal_instr, bus_error, instr_retired};
  endtask

  task automatic test_reset();
    step_t s; logic [2:0] st; logic [13:0] out;
    for (int i = 0; i < 3; i++) begin
      s = rnd_step(); s.rst = 1'b1;
      apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL reset cyc %0d: state=%0d out=%b, expected state=%0d out=%b", i, st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_rtype();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete(); gen(OP_R, 0, 0, 1'b0); gen(OP_R, 2, 0, 1'b1);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL rtype: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_lw();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete(); gen(OP_LW, 0, 3, 1'b0); gen(OP_LW, 1, 0, 1'b1);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL lw: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_sw();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete(); gen(OP_SW, 0, 0, 1'b0); gen(OP_SW, 0, 4, 1'b0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL sw: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_beq();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete(); gen(OP_BEQ, 0, 0, 1'b1); gen(OP_BEQ, 0, 0, 1'b0); gen(OP_BEQ, 3, 0, 1'b1);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL beq: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete(); gen(7'b0010011, 0, 0, 1'b0); gen(7'b1101111, 1, 0, 1'b1);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL illegal: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  // Fetch expiry, ready landing exactly on the expiry cycle, and expiry in both data waits.
  task automatic test_timeout();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete();
    gen(OP_R, 100, 0, 1'b0); gen(OP_R, TIMEOUT - 1, 0, 1'b0);
    gen(OP_LW, 0, 100, 1'b0); gen(OP_SW, 0, 100, 1'b0); gen(OP_SW, 0, TIMEOUT - 1, 1'b0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL timeout: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s; logic [2:0] st; logic [13:0] out;
    q.delete(); gen(OP_LW, 0, 0, 1'b0);
    // Script is FETCH, DECODE, ADDR, MEM_RD, WB_MEM: reset lands on the MEM_RD cycle.
    s = q[3]; s.rst = 1'b1; s.dr = 1'b1; s.st = 3'd0; s.out = '0; q[3] = s;
    void'(q.pop_back());
    gen(OP_R, 0, 0, 1'b0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL reset_mid: state=%0d out=%b, expected state=%0d out=%b", st, out, s.st, s.out);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s; logic [2:0] st; logic [13:0] out; logic [6:0] op; int fd, md;
    q.delete();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        default: op = 7'($urandom);
      endcase
      fd = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      md = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      gen(op, fd, md, 1'($urandom));
    end
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s, st, out); vectors++;
      if ({st, out} !== {s.st, s.out}) begin
        miscompares++;
        $display("FAIL back_to_back: op=%b state=%0d out=%b, expected state=%0d out=%b",
                 s.op, st, out, s.st, s.out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
